bloke2_hash_arb: RTL
====================

Name: bloke2_hash_arb

Overview:
- Multi-requester scheduler in front of the BLAKE2 message/data manager and hash core.
- Grants one requester at a time with round-robin fairness and sequences each job: start, byte stream, finish, result drain.
- Routes the W-byte digest stream back to the granted requester.
- Provides a result-timeout watchdog and a digest-length checker.

Parameters:
- N, 4, number of requesters (2..8).
- W, 32, hash word width; the digest is W bytes.
- TIMEOUT, 4096, max cycles in WAIT_RES without a result byte before abort.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-low reset.
- req  input  N  per-requester job request (level).
- req_data  input  N*8  per-requester byte; requester i on bits [i*8 +: 8].
- req_dv  input  N  per-requester byte valid.
- req_last  input  N  marks the final byte; with req_dv=0 it means end of an empty message.
- req_rdy  output  N  byte accepted this cycle when req_dv & req_rdy.
- gnt  output  N  one-hot current grant.
- out_data  output  8  digest byte, shared by all requesters.
- out_dv  output  N  digest byte valid, granted requester only.
- out_end  output  N  final digest byte, granted requester only.
- dm_start  output  1  job start pulse to the data manager.
- dm_data  output  8  byte to the data manager.
- dm_dv  output  1  byte valid to the data manager.
- dm_finish  output  1  finish level to the data manager.
- dm_drdy  input  1  data manager can accept a byte.
- res_data  input  8  digest byte from the data manager.
- res_dv  input  1  digest byte valid.
- res_end  input  1  last digest byte.
- busy  output  1  state != IDLE.
- err_timeout  output  1  one-cycle pulse on watchdog abort.
- err_len  output  1  one-cycle pulse when res_end arrives at a digest byte count != W.

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE; gnt=0, rr_ptr=0.
  - All outputs 0; digest byte counter and watchdog counter 0.
- IDLE:
  - If any req is high, grant the first asserted index at or after rr_ptr, searching cyclically.
  - Register gnt and go to START. One-cycle grant latency; gnt is valid from START onward.
- START:
  - dm_start=1 for exactly one cycle; then go to STREAM.
- STREAM:
  - req_rdy[g]=dm_drdy and is combinational; all other req_rdy bits are 0.
  - dm_dv = req_dv[g] & dm_drdy; dm_data = req_data[g]. Pure pass-through, zero latency.
  - Accepted byte with req_last[g]: dm_finish rises in the same cycle; go to FINISH.
  - req_last[g] with req_dv[g]=0 (empty message): dm_finish=1; go to FINISH with no byte sent.
  - Deasserting req[g] mid-stream is ignored; the grant holds until last.
- FINISH:
  - Hold dm_finish=1; clear the digest and watchdog counters; go to WAIT_RES next cycle.
- WAIT_RES:
  - dm_finish stays 1. out_data=res_data; out_dv[g]=res_dv; out_end[g]=res_end.
  - The watchdog counts while res_dv=0 and resets to 0 on res_dv. Each res_dv increments the digest counter.
  - On res_dv & res_end:
    - err_len pulses if count+1 != W.
    - dm_finish drops next cycle; rr_ptr <= (g+1) mod N; gnt <= 0; go to IDLE.
  - Watchdog reaches TIMEOUT-1:
    - err_timeout pulses and dm_start pulses once to clear the data manager.
    - rr_ptr advances, gnt <= 0, go to IDLE. The requester sees no out_end.
- Stray inputs:
  - res_dv outside WAIT_RES is dropped and produces no out_dv.
  - req_dv from non-granted requesters is never acknowledged.
- Simultaneous requests in IDLE: round-robin order only. Back-to-back jobs take at least 2 idle-to-start cycles.
- Async reset mid-job: everything returns to reset values immediately; no dm_start is emitted.

Test Plan:
- Single requester 0 sends 3 bytes 0x61,0x62,0x63 with last on 0x63 -> dm_start 1 cycle after gnt; 3 dm_dv beats with matching data; dm_finish asserted from the 0x63 cycle; 32 res bytes appear on out_dv[0] with out_end[0] on byte 32; busy ends; err_len=0.
- req=4'b1111 held with rr_ptr=0 -> grants in order 0,1,2,3,0; each job is a 1-byte message; no requester granted twice before all others.
- dm_drdy toggles 1,0,1,0 during a 4-byte stream -> req_rdy[g] mirrors dm_drdy; exactly 4 dm_dv beats; bytes unduplicated and in order.
- Empty message: req_last[1]=1 with req_dv=0 right after grant -> zero dm_dv beats; dm_finish=1; digest routed to out_dv[1].
- TIMEOUT=16 with res_dv never asserted -> err_timeout pulses 16 cycles after WAIT_RES entry, with a dm_start pulse; back in IDLE; next requester granted.
- res_end on the 20th digest byte -> err_len pulses once; job completes normally; rst low mid-stream -> gnt=0 and dm_* outputs=0 asynchronously.

Source files
------------

// File: rtl/bloke2_hash_arb.sv
`default_nettype none
// ============================================================================
// bloke2_hash_arb : round-robin job scheduler in front of the BLAKE2 data
// manager / hash core, with result watchdog and digest-length checker.
// Rev 1.0
// ============================================================================
module bloke2_hash_arb #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N-1:0]   req_i,
  input  logic [N*8-1:0] req_data_i,
  input  logic [N-1:0]   req_dv_i,
  input  logic [N-1:0]   req_last_i,
  output logic [N-1:0]   req_rdy_o,
  output logic [N-1:0]   gnt_o,
  output logic [7:0]     out_data_o,
  output logic [N-1:0]   out_dv_o,
  output logic [N-1:0]   out_end_o,
  output logic           dm_start_o,
  output logic [7:0]     dm_data_o,
  output logic           dm_dv_o,
  output logic           dm_finish_o,
  input  logic           dm_drdy_i,
  input  logic [7:0]     res_data_i,
  input  logic           res_dv_i,
  input  logic           res_end_i,
  output logic           busy_o,
  output logic           err_timeout_o,
  output logic           err_len_o
);

  localparam int c_iw = (N > 1) ? $clog2(N) : 1;
  localparam int c_sw = c_iw + 1;
  localparam int c_tw = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int c_cw = $clog2(W + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_STREAM = 3'd2,
    S_FINISH = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      gnt_q, gnt_d;
  logic [c_iw-1:0]   rr_ptr_q, rr_ptr_d;
  logic [c_tw-1:0]   wd_cnt_q, wd_cnt_d;
  logic [c_cw-1:0]   dig_cnt_q, dig_cnt_d;

  logic [c_iw-1:0]   w_g_idx;
  logic [c_iw-1:0]   w_rr_next;
  logic [c_iw-1:0]   w_pick_idx;
  logic              w_pick_vld;
  logic [c_sw-1:0]   w_cand;
  logic [7:0]        w_sel_data;

  always_comb begin
    w_g_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q[i]) w_g_idx = c_iw'(i);
    end
  end

  // First requester at or after rr_ptr, wrapping cyclically.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_cand     = '0;
    for (int i = 0; i < N; i++) begin
      w_cand = {1'b0, rr_ptr_q} + c_sw'(i);
      if (w_cand >= c_sw'(N)) w_cand = w_cand - c_sw'(N);
      if (!w_pick_vld && req_i[w_cand[c_iw-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_cand[c_iw-1:0];
      end
    end
  end

  assign w_rr_next  = (w_g_idx == c_iw'(N - 1)) ? '0 : w_g_idx + c_iw'(1);
  assign w_sel_data = req_data_i[w_g_idx*8 +: 8];
  assign gnt_o      = gnt_q;
  assign busy_o     = (state_q != S_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      rr_ptr_q  <= '0;
      wd_cnt_q  <= '0;
      dig_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_ptr_q  <= rr_ptr_d;
      wd_cnt_q  <= wd_cnt_d;
      dig_cnt_q <= dig_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    rr_ptr_d      = rr_ptr_q;
    wd_cnt_d      = wd_cnt_q;
    dig_cnt_d     = dig_cnt_q;
    req_rdy_o     = '0;
    out_data_o    = '0;
    out_dv_o      = '0;
    out_end_o     = '0;
    dm_start_o    = 1'b0;
    dm_data_o     = '0;
    dm_dv_o       = 1'b0;
    dm_finish_o   = 1'b0;
    err_timeout_o = 1'b0;
    err_len_o     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (w_pick_vld) begin
          gnt_d             = '0;
          gnt_d[w_pick_idx] = 1'b1;
          state_d           = S_START;
        end
      end
      S_START: begin
        dm_start_o = 1'b1;
        state_d    = S_STREAM;
      end
      S_STREAM: begin
        req_rdy_o = gnt_q & {N{dm_drdy_i}};
        dm_data_o = w_sel_data;
        dm_dv_o   = req_dv_i[w_g_idx] & dm_drdy_i;
        // A last flag without a byte closes an empty message.
        if (req_last_i[w_g_idx] && (!req_dv_i[w_g_idx] || dm_drdy_i)) begin
          dm_finish_o = 1'b1;
          state_d     = S_FINISH;
        end
      end
      S_FINISH: begin
        dm_finish_o = 1'b1;
        wd_cnt_d    = '0;
        dig_cnt_d   = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        dm_finish_o = 1'b1;
        out_data_o  = res_data_i;
        out_dv_o    = gnt_q & {N{res_dv_i}};
        out_end_o   = gnt_q & {N{res_end_i}};
        if (res_dv_i) begin
          wd_cnt_d = '0;
          if (dig_cnt_q != '1) dig_cnt_d = dig_cnt_q + c_cw'(1);
          if (res_end_i) begin
            err_len_o = (dig_cnt_q != c_cw'(W - 1));
            rr_ptr_d  = w_rr_next;
            gnt_d     = '0;
            state_d   = S_IDLE;
          end
        end else if (wd_cnt_q == c_tw'(TIMEOUT - 1)) begin
          // Abort: re-pulse start so the data manager drops the stalled job.
          err_timeout_o = 1'b1;
          dm_start_o    = 1'b1;
          rr_ptr_d      = w_rr_next;
          gnt_d         = '0;
          state_d       = S_IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + c_tw'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

endmodule
`default_nettype wire
